// File: rtl/flow_table_config.sv
// flow_table_config: control-side writer for the flow director lookup table.
//   Accepts INSERT/DELETE/CLEAR_ALL commands over valid/ready and runs
//   read-check-write sequences on the table RAM ports.
//   It keeps a count of valid entries and returns one status per command.
// Ports:
//   clk, rst (async, active-low)
//   in_cfg_*       command channel (op, idx, key, queue)
//   tbl_rd_*       table read strobe/address; tbl_rd_vld_bit returns 1 cycle later
//   tbl_wr_*       table write strobe/address/data {valid, key, queue}
//   tbl_busy       high while a CLEAR_ALL sweep is running
//   out_resp_*     response channel (echoed op, status)
//   occupancy      number of valid entries
module flow_table_config #(
  parameter int KEY_W   = 96,
  parameter int QUEUE_W = 16,
  parameter int IDX_W   = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_cfg_valid,
  output logic                       in_cfg_ready,
  input  logic [1:0]                 in_cfg_op,
  input  logic [IDX_W-1:0]           in_cfg_idx,
  input  logic [KEY_W-1:0]           in_cfg_key,
  input  logic [QUEUE_W-1:0]         in_cfg_queue,
  output logic                       tbl_rd_en,
  output logic [IDX_W-1:0]           tbl_rd_addr,
  input  logic                       tbl_rd_vld_bit,
  output logic                       tbl_wr_en,
  output logic [IDX_W-1:0]           tbl_wr_addr,
  output logic [KEY_W+QUEUE_W:0]     tbl_wr_data,
  output logic                       tbl_busy,
  output logic                       out_resp_valid,
  input  logic                       out_resp_ready,
  output logic [1:0]                 out_resp_op,
  output logic [1:0]                 out_resp_status,
  output logic [IDX_W:0]             occupancy
);
  localparam logic [1:0] OP_INS = 2'd0;
  localparam logic [1:0] OP_DEL = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;
  localparam logic [1:0] OP_BAD = 2'd3;
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_REPL = 2'd1;
  localparam logic [1:0] ST_NF   = 2'd2;
  localparam logic [1:0] ST_BAD  = 2'd3;
  localparam logic [IDX_W:0] OCC_MAX = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, RD, CHK, CLR, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [QUEUE_W-1:0]   queue_q, queue_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W:0]       occ_q, occ_d;
  logic [1:0]           status_q, status_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 chk, chk_wr, wr_ins;

  // The valid bit only arrives in CHK, so the CHK write is decoded from it directly.
  assign chk    = state_q == CHK;
  assign chk_wr = chk && (op_q == OP_INS || tbl_rd_vld_bit);
  assign wr_ins = chk && op_q == OP_INS;

  assign in_cfg_ready    = state_q == IDLE;
  assign tbl_rd_en       = rd_en_q;
  assign tbl_rd_addr     = rd_en_q ? idx_q : '0;
  assign tbl_wr_en       = busy_q | chk_wr;
  assign tbl_wr_addr     = busy_q ? cnt_q : chk_wr ? idx_q : '0;
  assign tbl_wr_data     = wr_ins ? {1'b1, key_q, queue_q} : '0;
  assign tbl_busy        = busy_q;
  assign out_resp_valid  = resp_valid_q;
  assign out_resp_op     = op_q;
  assign out_resp_status = status_q;
  assign occupancy       = occ_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    key_d        = key_q;
    queue_d      = queue_q;
    cnt_d        = cnt_q;
    occ_d        = occ_q;
    status_d     = status_q;
    rd_en_d      = 1'b0;
    busy_d       = busy_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      IDLE: if (in_cfg_valid) begin
        op_d         = in_cfg_op;
        idx_d        = in_cfg_idx;
        key_d        = in_cfg_key;
        queue_d      = in_cfg_queue;
        cnt_d        = '0;
        state_d      = in_cfg_op == OP_CLR ? CLR : in_cfg_op == OP_BAD ? RESP : RD;
        rd_en_d      = in_cfg_op == OP_INS || in_cfg_op == OP_DEL;
        busy_d       = in_cfg_op == OP_CLR;
        resp_valid_d = in_cfg_op == OP_BAD;
        status_d     = ST_BAD;
      end
      RD: state_d = CHK;
      CHK: begin
        status_d     = op_q == OP_INS ? (tbl_rd_vld_bit ? ST_REPL : ST_OK)
                                      : (tbl_rd_vld_bit ? ST_OK : ST_NF);
        occ_d        = (op_q == OP_INS && !tbl_rd_vld_bit && occ_q != OCC_MAX) ? occ_q + (IDX_W+1)'(1)
                     : (op_q == OP_DEL && tbl_rd_vld_bit && occ_q != '0) ? occ_q - (IDX_W+1)'(1)
                     : occ_q;
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      // Stop on the last address instead of incrementing so the counter never wraps.
      CLR: if (&cnt_q) begin
        busy_d       = 1'b0;
        occ_d        = '0;
        status_d     = ST_OK;
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
      RESP: if (out_resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      idx_q        <= '0;
      key_q        <= '0;
      queue_q      <= '0;
      cnt_q        <= '0;
      occ_q        <= '0;
      status_q     <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      queue_q      <= queue_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
      status_q     <= status_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  occ_bound: assert property (@(posedge clk) disable iff (!rst) occ_q <= OCC_MAX);

endmodule

// File: tb/tb_flow_table_config.sv
// tb_flow_table_config: scoreboard bench for flow_table_config with a 16-entry table.
module tb_flow_table_config;
  localparam int KEY_W = 96, QUEUE_W = 16, IDX_W = 4;
  localparam int DW = 1 + KEY_W + QUEUE_W, N = 1 << IDX_W;

  logic clk = 1'b0, rst = 1'b0;
  logic in_cfg_valid = 1'b0, in_cfg_ready;
  logic [1:0] in_cfg_op = '0;
  logic [IDX_W-1:0] in_cfg_idx = '0;
  logic [KEY_W-1:0] in_cfg_key = '0;
  logic [QUEUE_W-1:0] in_cfg_queue = '0;
  logic tbl_rd_en, tbl_wr_en, tbl_busy, tbl_rd_vld_bit = 1'b0;
  logic [IDX_W-1:0] tbl_rd_addr, tbl_wr_addr;
  logic [DW-1:0] tbl_wr_data;
  logic out_resp_valid, out_resp_ready = 1'b0;
  logic [1:0] out_resp_op, out_resp_status;
  logic [IDX_W:0] occupancy;

  always #5 clk = ~clk;

  flow_table_config #(.KEY_W(KEY_W), .QUEUE_W(QUEUE_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_cfg_valid(in_cfg_valid), .in_cfg_ready(in_cfg_ready), .in_cfg_op(in_cfg_op),
    .in_cfg_idx(in_cfg_idx), .in_cfg_key(in_cfg_key), .in_cfg_queue(in_cfg_queue),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_vld_bit(tbl_rd_vld_bit),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_busy(tbl_busy), .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready),
    .out_resp_op(out_resp_op), .out_resp_status(out_resp_status), .occupancy(occupancy)
  );

  // Table RAM valid bits; powers up dirty to show that CLEAR_ALL is needed.
  logic [N-1:0] mem_v = '1;
  always @(posedge clk) begin
    tbl_rd_vld_bit <= tbl_rd_en ? mem_v[tbl_rd_addr] : 1'b0;
    if (tbl_wr_en) mem_v[tbl_wr_addr] <= tbl_wr_data[DW-1];
  end

  logic [N-1:0] ref_v = '1;
  int ref_occ = 0;
  logic [3:0] exp_q[$];

  int checks = 0, failures = 0;
  int lat, rd_cnt, wr_cnt, busy_cnt, rd_lat, wr_lat, n;
  logic [IDX_W-1:0] rd_addr_s, wr_addr_s;
  logic [DW-1:0] wr_data_s;
  bit seq_ok, ready_low, quiet;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [IDX_W-1:0] idx,
                       input logic [KEY_W-1:0] key, input logic [QUEUE_W-1:0] qid);
    logic [1:0] st;
    st = op == 2'd3 ? 2'd3 : op == 2'd2 ? 2'd0
       : op == 2'd0 ? (ref_v[idx] ? 2'd1 : 2'd0) : (ref_v[idx] ? 2'd0 : 2'd2);
    if (op == 2'd2) begin ref_v = '0; ref_occ = 0; end
    else if (op == 2'd0) begin if (!ref_v[idx]) ref_occ++; ref_v[idx] = 1'b1; end
    else if (op == 2'd1) begin if (ref_v[idx]) ref_occ--; ref_v[idx] = 1'b0; end
    exp_q.push_back({op, st});
    check("cfg_ready_idle", in_cfg_ready, 1);
    in_cfg_valid = 1'b1; in_cfg_op = op; in_cfg_idx = idx; in_cfg_key = key; in_cfg_queue = qid;
    @(posedge clk);
    @(negedge clk);
    in_cfg_valid = 1'b0;
    in_cfg_op = 2'($urandom); in_cfg_idx = IDX_W'($urandom);
    in_cfg_key = {$urandom, $urandom, $urandom}; in_cfg_queue = QUEUE_W'($urandom);
    lat = 1; rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; rd_lat = 0; wr_lat = 0;
    rd_addr_s = '0; wr_addr_s = '0; wr_data_s = '0; seq_ok = 1; ready_low = 1;
    while (!out_resp_valid && lat < N + 50) begin
      if (tbl_rd_en) begin rd_cnt++; rd_lat = lat; rd_addr_s = tbl_rd_addr; end
      if (tbl_wr_en) begin
        if (tbl_busy && (tbl_wr_addr != IDX_W'(wr_cnt) || tbl_wr_data != '0)) seq_ok = 0;
        wr_cnt++; wr_lat = lat; wr_addr_s = tbl_wr_addr; wr_data_s = tbl_wr_data;
      end
      if (tbl_busy) busy_cnt++;
      if (in_cfg_ready) ready_low = 0;
      @(negedge clk);
      lat++;
    end
    check("resp_valid_seen", out_resp_valid, 1);
    check("cfg_ready_busy", ready_low, 1);
  endtask

  task automatic take_resp(input int stall);
    logic [3:0] snap, exp;
    bit stable;
    stable = 1;
    snap = {out_resp_op, out_resp_status};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!out_resp_valid || {out_resp_op, out_resp_status} != snap || in_cfg_ready ||
          tbl_rd_en || tbl_wr_en || tbl_busy) stable = 0;
    end
    if (stall > 0) check("stall_stable", stable, 1);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 4'bxxxx;
    check("resp_op_status", {out_resp_op, out_resp_status}, exp);
    out_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_resp_ready = 1'b0;
    check("resp_dropped", out_resp_valid, 0);
    check("occupancy", occupancy, ref_occ);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rd_en", tbl_rd_en, 0);
    check("rst_wr_en", tbl_wr_en, 0);
    check("rst_busy", tbl_busy, 0);
    check("rst_resp_valid", out_resp_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_addr_data", {tbl_rd_addr, tbl_wr_addr, tbl_wr_data}, 0);
    rst = 1'b1;
    @(negedge clk);

    issue(2'd2, '0, '0, '0);
    check("clr_latency", lat, N + 1);
    check("clr_wr_cnt", wr_cnt, N);
    check("clr_seq", seq_ok, 1);
    check("clr_busy_cnt", busy_cnt, N);
    check("clr_rd_cnt", rd_cnt, 0);
    take_resp(0);

    issue(2'd0, 4'd5, 96'hA, 16'h3);
    check("ins_rd_cnt", rd_cnt, 1);
    check("ins_rd_lat", rd_lat, 1);
    check("ins_rd_addr", rd_addr_s, 5);
    check("ins_wr_cnt", wr_cnt, 1);
    check("ins_wr_lat", wr_lat, 2);
    check("ins_wr_addr", wr_addr_s, 5);
    check("ins_wr_data", wr_data_s, {1'b1, 96'hA, 16'h3});
    check("ins_latency", lat, 3);
    take_resp(0);

    issue(2'd0, 4'd5, 96'hB, 16'h4);
    check("repl_wr_data", wr_data_s, {1'b1, 96'hB, 16'h4});
    take_resp(0);

    issue(2'd1, 4'd5, '0, '0);
    check("del_wr_cnt", wr_cnt, 1);
    check("del_wr_data", wr_data_s, 0);
    check("del_latency", lat, 3);
    take_resp(2);

    issue(2'd1, 4'd7, '0, '0);
    check("nf_wr_cnt", wr_cnt, 0);
    check("nf_rd_cnt", rd_cnt, 1);
    check("nf_latency", lat, 3);
    take_resp(0);

    issue(2'd3, 4'd9, '0, '0);
    check("bad_rd_cnt", rd_cnt, 0);
    check("bad_wr_cnt", wr_cnt, 0);
    check("bad_latency", lat, 1);
    take_resp(10);

    for (int i = 0; i < 14; i++) begin
      issue(2'($urandom_range(0, 1)), IDX_W'($urandom_range(0, N - 1)),
            {$urandom, $urandom, $urandom}, QUEUE_W'($urandom));
      check("rand_latency", lat, 3);
      take_resp(int'($urandom_range(0, 2)));
    end
    check("table_contents", mem_v, ref_v);

    // Abort a sweep with reset while address 6 is being presented.
    in_cfg_valid = 1'b1; in_cfg_op = 2'd2;
    @(posedge clk);
    @(negedge clk);
    in_cfg_valid = 1'b0;
    n = 0;
    while (!(tbl_busy && tbl_wr_addr == 4'd6) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("clr_reach_6", {tbl_busy, tbl_wr_addr}, {1'b1, 4'd6});
    #2 rst = 1'b0;
    #1;
    check("abort_busy", tbl_busy, 0);
    check("abort_wr_en", tbl_wr_en, 0);
    check("abort_rd_en", tbl_rd_en, 0);
    check("abort_resp_valid", out_resp_valid, 0);
    check("abort_occupancy", occupancy, 0);
    ref_v[5:0] = '0;
    ref_occ = 0;
    @(negedge clk);
    rst = 1'b1;
    quiet = 1;
    repeat (3) begin
      @(negedge clk);
      if (out_resp_valid || tbl_busy || tbl_wr_en) quiet = 0;
    end
    check("abort_no_resp", quiet, 1);
    check("abort_table", mem_v, ref_v);

    issue(2'd0, 4'd12, 96'h1234, 16'h77);
    check("post_abort_latency", lat, 3);
    take_resp(0);
    issue(2'd0, 4'd2, 96'h55, 16'h9);
    check("post_abort_wr_addr", wr_addr_s, 2);
    take_resp(1);
    check("final_table", mem_v, ref_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flow_table_config.md
Name: flow_table_config

Overview:
- Control-side writer for the flow director's lookup table.
- Accepts insert/delete/clear commands from the PCIe configuration path over a valid/ready handshake.
- Performs read-check-write sequences on the table's memory ports, maintains an occupancy count, and returns one status response per command.
- Sits between the PCIe config decoder and the flow table RAM that the flow director reads.

Parameters:
KEY_W, 96, flow key width (src/dst IP + src/dst port)
QUEUE_W, 16, destination queue id width
IDX_W, 13, table index width; table has 2**IDX_W entries

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
in_cfg_valid  in  1  command valid
in_cfg_ready  out  1  command accepted when valid&ready
in_cfg_op  in  2  0=INSERT, 1=DELETE, 2=CLEAR_ALL, 3=reserved
in_cfg_idx  in  IDX_W  target entry
in_cfg_key  in  KEY_W  key (INSERT only)
in_cfg_queue  in  QUEUE_W  queue id (INSERT only)
tbl_rd_en  out  1  table read strobe
tbl_rd_addr  out  IDX_W  read address
tbl_rd_vld_bit  in  1  valid bit of addressed entry, 1 cycle after tbl_rd_en
tbl_wr_en  out  1  table write strobe
tbl_wr_addr  out  IDX_W  write address
tbl_wr_data  out  1+KEY_W+QUEUE_W  {valid, key, queue}
tbl_busy  out  1  high during CLEAR_ALL sweep; flow director treats all lookups as miss
out_resp_valid  out  1  response valid
out_resp_ready  in  1  response consumed
out_resp_op  out  2  echoed op
out_resp_status  out  2  0=OK, 1=REPLACED, 2=NOT_FOUND, 3=BAD_OP
occupancy  out  IDX_W+1  number of valid entries

Behaviour:
- Reset (rst low, async): state IDLE; all strobes, tbl_busy and out_resp_valid are 0; occupancy is 0; addresses and data are 0. Table RAM is not cleared by reset. Software issues CLEAR_ALL after reset.
- Command capture:
  - in_cfg_ready=1 only in state IDLE.
  - On handshake, op, idx, key and queue are registered. Held inputs are ignored until the next IDLE.
- FSM states: IDLE, RD, CHK, CLR, RESP.
  - IDLE to RD on INSERT/DELETE.
  - IDLE to CLR on CLEAR_ALL.
  - IDLE to RESP on op 3, status BAD_OP, no table access.
  - RD: tbl_rd_en=1 for exactly one cycle, tbl_rd_addr=idx. Next state CHK.
  - CHK: samples tbl_rd_vld_bit (v).
    - INSERT: tbl_wr_en=1, data {1,key,queue}. Status REPLACED if v, else OK. occupancy+1 only if !v.
    - DELETE with v: tbl_wr_en=1, data all-zero, status OK, occupancy-1.
    - DELETE with !v: no write, status NOT_FOUND.
    - Next state RESP.
  - CLR:
    - Sweep counter starts at 0. One write per cycle: tbl_wr_en=1, addr=counter, data=0. tbl_busy=1 for every CLR cycle.
    - After address 2**IDX_W-1 is written: occupancy=0, status OK, next state RESP.
    - Sweep length is exactly 2**IDX_W cycles. The counter must not wrap to 0 a second time.
  - RESP: out_resp_valid=1, with op/status stable until out_resp_ready. On handshake, go to IDLE.
    - A new command can be accepted in the cycle after the response handshake, not in the same cycle.
- Latency:
  - INSERT/DELETE: accept at cycle T, RD at T+1, write and status at T+2, out_resp_valid at T+3.
  - CLEAR_ALL: out_resp_valid at T+1+2**IDX_W.
  - BAD_OP: out_resp_valid at T+1.
- Occupancy:
  - Saturates at 2**IDX_W and never underflows. Saturation is unreachable by construction; it is checked by assertion.
- Back-pressure: out_resp_ready low stalls in RESP indefinitely. No table activity occurs while stalled.
- Mid-operation reset: an async reset during CLR aborts the sweep. The table is left partially cleared, tbl_busy drops immediately and no response is issued.
- No buffering: at most one command is in flight.

Test Plan:
- Reset, CLEAR_ALL with IDX_W=4 -> 16 consecutive writes, addr 0..15, data 0; tbl_busy high for exactly 16 cycles; response status OK at T+17; occupancy 0.
- INSERT idx=5, key=0xA, queue=3 on empty entry -> rd at T+1; write {1,0xA,3} to addr 5 at T+2; status OK at T+3; occupancy 1.
- INSERT idx=5 again with v=1 -> status REPLACED; occupancy stays 1; DELETE idx=5 -> write zero, OK, occupancy 0.
- DELETE idx=7 on empty entry -> no tbl_wr_en; status NOT_FOUND; occupancy unchanged.
- op=3 -> no rd/wr strobes; BAD_OP at T+1. Hold out_resp_ready low 10 cycles -> in_cfg_ready stays 0 and response fields stay stable.
- Assert rst low at sweep index 6 of CLEAR_ALL -> all outputs 0 asynchronously; no response; after release, in_cfg_ready=1 and a new INSERT completes normally.
